// File: rtl/hilo_div_unit_if.sv
// ---------------------------------------------------------------------------
// hilo_div_unit_if
// Handshake/operand bundle between the MIPS EX stage (master) and the HI/LO
// divider (slave). Signal names follow the core's existing divider naming.
//
// Signals
//   StartDiv  master->slave  request a divide
//   Sign      master->slave  1 = signed (div), 0 = unsigned (divu)
//   Annul     master->slave  cancel the in-flight divide
//   SrcA      master->slave  dividend
//   SrcB      master->slave  divisor
//   Busy      slave->master  divide in progress
//   Ready     slave->master  one-cycle result-valid pulse
//   DivZero   slave->master  divisor was zero
//   Result    slave->master  {remainder, quotient}
// ---------------------------------------------------------------------------
interface hilo_div_unit_if #(
    parameter int WIDTH = 32
);
    logic               StartDiv;
    logic               Sign;
    logic               Annul;
    logic [WIDTH-1:0]   SrcA;
    logic [WIDTH-1:0]   SrcB;
    logic               Busy;
    logic               Ready;
    logic               DivZero;
    logic [2*WIDTH-1:0] Result;

    modport master (
        output StartDiv, Sign, Annul, SrcA, SrcB,
        input  Busy, Ready, DivZero, Result
    );

    modport slave (
        input  StartDiv, Sign, Annul, SrcA, SrcB,
        output Busy, Ready, DivZero, Result
    );
endinterface

// File: rtl/hilo_div_unit.sv
// ---------------------------------------------------------------------------
// hilo_div_unit
// Iterative restoring signed/unsigned divider that feeds the HI/LO registers.
// Remainder lands in Result[2*WIDTH-1:WIDTH] (HI), quotient in
// Result[WIDTH-1:0] (LO).
//
// Parameters
//   WIDTH           operand width (even, >= 4)
//   BITS_PER_CYCLE  quotient bits resolved per cycle (1 or 2, divides WIDTH)
//
// Ports
//   clk   clock
//   rst   synchronous reset, active-high; drops any divide in flight
//   bus   hilo_div_unit_if.slave: StartDiv/Sign/Annul/SrcA/SrcB in,
//         Busy/Ready/DivZero/Result out
//
// Optional feature
//   DIV_EARLY_OUT_EN  when defined, a divisor whose magnitude exceeds the
//                     dividend's finishes immediately with quotient 0 and
//                     remainder = dividend.
// ---------------------------------------------------------------------------
module hilo_div_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    hilo_div_unit_if.slave  bus
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [SW-1:0]      r_step;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH:0]     r_rem;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_busy;
    logic               r_ready;
    logic               r_divZero;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic               w_accept;
    logic               w_zero;
    logic               w_early;
    logic [WIDTH:0]     w_remNext;
    logic [WIDTH-1:0]   w_quotNext;
    logic [WIDTH-1:0]   w_quotFix;
    logic [WIDTH-1:0]   w_remFix;

    // Operand magnitudes: only signed requests with a negative operand get
    // negated; the true signs are restored when the result is written.
    assign w_absA   = (bus.Sign && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    assign w_absB   = (bus.Sign && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

    // A start is only looked at outside CALC, and Annul always suppresses it.
    assign w_accept = (r_state != S_CALC) && bus.StartDiv && !bus.Annul;
    assign w_zero   = (bus.SrcB == '0);

`ifdef DIV_EARLY_OUT_EN
    // Divisor larger than dividend: quotient is trivially zero.
    assign w_early  = (w_absB > w_absA);
`else
    assign w_early  = 1'b0;
`endif

    // One CALC cycle of restoring division. r_quot starts as the dividend and
    // is shifted out MSB-first into the partial remainder while quotient bits
    // shift in at the bottom. The remainder carries one extra bit because the
    // shifted partial remainder can reach 2*divisor-1.
    always_comb begin
        logic [WIDTH:0]   remWork;
        logic [WIDTH-1:0] quotWork;
        remWork  = r_rem;
        quotWork = r_quot;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            remWork  = {remWork[WIDTH-1:0], quotWork[WIDTH-1]};
            quotWork = {quotWork[WIDTH-2:0], 1'b0};
            if (remWork >= {1'b0, r_divisor}) begin
                remWork     = remWork - {1'b0, r_divisor};
                quotWork[0] = 1'b1;
            end
        end
        w_remNext  = remWork;
        w_quotNext = quotWork;
    end

    // Sign fix-up applied on the final step. MIN / -1 needs no special case:
    // both signs are negative so the quotient is not negated and the unsigned
    // quotient 2^(WIDTH-1) is already the wrapped MIN value.
    assign w_quotFix = r_qneg ? -w_quotNext : w_quotNext;
    assign w_remFix  = r_rneg ? -w_remNext[WIDTH-1:0] : w_remNext[WIDTH-1:0];

    // Main FSM. Busy and Ready are registered alongside the state so they
    // track CALC and DONE exactly. Result and DivZero are only touched when a
    // divide completes or a new start is accepted, so an annulled divide
    // leaves the previous values visible to the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_step    <= '0;
            r_divisor <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_divZero <= 1'b0;
            r_result  <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_busy <= 1'b0;
                    if (w_accept) begin
                        r_divZero <= w_zero;
                        r_qneg    <= bus.Sign & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                        r_rneg    <= bus.Sign & bus.SrcA[WIDTH-1];
                        r_quot    <= w_absA;
                        r_rem     <= '0;
                        r_divisor <= w_absB;
                        r_step    <= '0;
                        if (w_zero) begin
                            r_result <= {bus.SrcA, {WIDTH{1'b1}}};
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_early) begin
                            r_result <= {bus.SrcA, {WIDTH{1'b0}}};
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_busy   <= 1'b1;
                            r_state  <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_CALC: begin
                    if (bus.Annul) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem  <= w_remNext;
                        r_quot <= w_quotNext;
                        r_step <= r_step + SW'(1);
                        if (r_step == LAST_STEP) begin
                            r_result <= {w_remFix, w_quotFix};
                            r_busy   <= 1'b0;
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy    = r_busy;
    assign bus.Ready   = r_ready;
    assign bus.DivZero = r_divZero;
    assign bus.Result  = r_result;

endmodule

// File: tb/tb_hilo_div_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_div_unit
// Directed bench for hilo_div_unit. Instance dut uses the default 32-bit,
// 1-bit-per-cycle build; instance dut2 uses 2 bits per cycle. Cycle 0 is the
// cycle in which StartDiv is presented; outputs are sampled 1 time unit after
// each rising edge. Expected early-out timing follows DIV_EARLY_OUT_EN.
// ---------------------------------------------------------------------------
module tb_hilo_div_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    hilo_div_unit_if #(.WIDTH(32)) bus  ();
    hilo_div_unit_if #(.WIDTH(32)) bus2 ();

    hilo_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    hilo_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 unit after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the request inputs of the selected instance (0 = dut, 1 = dut2).
    task automatic applyStimulus(input int sel, input logic start, input logic sign,
                                 input logic annul, input logic [31:0] a,
                                 input logic [31:0] b);
        if (sel == 1) begin
            bus2.StartDiv = start;
            bus2.Sign     = sign;
            bus2.Annul    = annul;
            bus2.SrcA     = a;
            bus2.SrcB     = b;
        end else begin
            bus.StartDiv  = start;
            bus.Sign      = sign;
            bus.Annul     = annul;
            bus.SrcA      = a;
            bus.SrcB      = b;
        end
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic getReady(input int sel);
        return (sel == 1) ? bus2.Ready : bus.Ready;
    endfunction

    function automatic logic getBusy(input int sel);
        return (sel == 1) ? bus2.Busy : bus.Busy;
    endfunction

    function automatic logic getDivZero(input int sel);
        return (sel == 1) ? bus2.DivZero : bus.DivZero;
    endfunction

    function automatic logic [63:0] getResult(input int sel);
        return (sel == 1) ? bus2.Result : bus.Result;
    endfunction

    // Present a start in the current cycle (cycle 0); returns in cycle 1.
    task automatic startOp(input int sel, input logic sign, input logic [31:0] a,
                           input logic [31:0] b);
        applyStimulus(sel, 1'b1, sign, 1'b0, a, b);
        stepCycle();
        applyStimulus(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Wait (bounded) for Ready, counting cycles from startCyc and counting
    // cycles where Busy differs from expectBusy before Ready.
    task automatic waitReady(input int sel, input int startCyc, input logic expectBusy,
                             output int cyc, output int busyBad);
        cyc     = startCyc;
        busyBad = 0;
        while (cyc <= 200 && !getReady(sel)) begin
            if (getBusy(sel) !== expectBusy) busyBad++;
            stepCycle();
            cyc++;
        end
    endtask

    // Full divide from start to the cycle after Ready.
    task automatic runDivide(input string tag, input int sel, input logic sign,
                             input logic [31:0] a, input logic [31:0] b,
                             input int expCyc, input logic [63:0] expRes,
                             input logic expDz);
        int cyc;
        int busyBad;
        startOp(sel, sign, a, b);
        waitReady(sel, 1, (expCyc > 1), cyc, busyBad);
        checkOutput({tag, "_readyCycle"}, 64'(cyc), 64'(expCyc));
        checkOutput({tag, "_result"}, getResult(sel), expRes);
        checkOutput({tag, "_divZero"}, 64'(getDivZero(sel)), 64'(expDz));
        checkOutput({tag, "_busyProfile"}, 64'(busyBad), 64'd0);
        checkOutput({tag, "_busyAtReady"}, 64'(getBusy(sel)), 64'd0);
        stepCycle();
        checkOutput({tag, "_readyPulse"}, 64'(getReady(sel)), 64'd0);
    endtask

    initial begin
        int cyc;
        int busyBad;
        int readySeen;
        int earlyCyc;

        checks   = 0;
        failures = 0;
`ifdef DIV_EARLY_OUT_EN
        earlyCyc = 1;
`else
        earlyCyc = 33;
`endif
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        stepCycle();
        stepCycle();

        // Reset state.
        checkOutput("rst_busy",    64'(bus.Busy),    64'd0);
        checkOutput("rst_ready",   64'(bus.Ready),   64'd0);
        checkOutput("rst_divZero", 64'(bus.DivZero), 64'd0);
        checkOutput("rst_result",  bus.Result,       64'd0);
        checkOutput("rst_result2", bus2.Result,      64'd0);
        rst = 1'b0;
        stepCycle();

        $display("[TB] basic unsigned/signed divides");
        runDivide("u100_7", 0, 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0);
        runDivide("sneg7_2", 0, 1'b1, 32'hFFFFFFF9, 32'd2, 33,
                  {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
        runDivide("sovf", 0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 33,
                  {32'h00000000, 32'h80000000}, 1'b0);
        runDivide("sneg100_7", 0, 1'b1, 32'hFFFFFF9C, 32'd7, 33,
                  {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0);
        runDivide("s100_neg7", 0, 1'b1, 32'd100, 32'hFFFFFFF9, 33,
                  {32'd2, 32'hFFFFFFF2}, 1'b0);
        runDivide("u_big", 0, 1'b0, 32'hFFFFFFF9, 32'd2, 33,
                  {32'd1, 32'h7FFFFFFC}, 1'b0);

        $display("[TB] divide by zero");
        runDivide("u5_0", 0, 1'b0, 32'd5, 32'd0, 1, {32'd5, 32'hFFFFFFFF}, 1'b1);
        runDivide("s5_0", 0, 1'b1, 32'd5, 32'd0, 1, {32'd5, 32'hFFFFFFFF}, 1'b1);
        stepCycle();
        checkOutput("dz_held", 64'(bus.DivZero), 64'd1);
        runDivide("dz_clear", 0, 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0);

        $display("[TB] start ignored while calculating");
        startOp(0, 1'b0, 32'd50, 32'd6);
        repeat (4) stepCycle();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd10);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        waitReady(0, 6, 1'b1, cyc, busyBad);
        checkOutput("ign_readyCycle", 64'(cyc), 64'd33);
        checkOutput("ign_result", bus.Result, {32'd2, 32'd8});
        stepCycle();

        $display("[TB] annul in CALC");
        runDivide("pre_annul", 0, 1'b1, 32'hFFFFFFF9, 32'd2, 33,
                  {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
        readySeen = 0;
        startOp(0, 1'b0, 32'd100, 32'd7);
        for (int i = 1; i < 10; i++) begin
            if (bus.Ready) readySeen++;
            stepCycle();
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        if (bus.Ready) readySeen++;
        checkOutput("annul_busy", 64'(bus.Busy), 64'd0);
        checkOutput("annul_noReady", 64'(readySeen), 64'd0);
        checkOutput("annul_result", bus.Result, {32'hFFFFFFFF, 32'hFFFFFFFD});
        stepCycle();
        runDivide("post_annul", 0, 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 1'b0);

        $display("[TB] back-to-back issue");
        startOp(0, 1'b0, 32'd1000, 32'd9);
        waitReady(0, 1, 1'b1, cyc, busyBad);
        checkOutput("b2b_first_cycle", 64'(cyc), 64'd33);
        checkOutput("b2b_first_result", bus.Result, {32'd1, 32'd111});
        startOp(0, 1'b0, 32'd50, 32'd6);
        checkOutput("b2b_busy_next", 64'(bus.Busy), 64'd1);
        waitReady(0, 1, 1'b1, cyc, busyBad);
        checkOutput("b2b_second_cycle", 64'(cyc), 64'd33);
        checkOutput("b2b_second_result", bus.Result, {32'd2, 32'd8});

        $display("[TB] annul wins over start in DONE");
        startOp(0, 1'b0, 32'd100, 32'd7);
        waitReady(0, 1, 1'b1, cyc, busyBad);
        checkOutput("annulDone_ready", 64'(bus.Ready), 64'd1);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'd9, 32'd3);
        stepCycle();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("annulDone_busy", 64'(bus.Busy), 64'd0);
        checkOutput("annulDone_readyLow", 64'(bus.Ready), 64'd0);
        stepCycle();
        checkOutput("annulDone_result", bus.Result, {32'd2, 32'd14});

        $display("[TB] reset mid-operation");
        startOp(0, 1'b0, 32'd1000, 32'd9);
        repeat (4) stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("midrst_status", {61'd0, bus.Busy, bus.Ready, bus.DivZero}, 64'd0);
        checkOutput("midrst_result", bus.Result, 64'd0);
        rst = 1'b0;
        stepCycle();

        $display("[TB] divisor larger than dividend");
        runDivide("u3_10", 0, 1'b0, 32'd3, 32'd10, earlyCyc, {32'd3, 32'd0}, 1'b0);
        runDivide("sneg3_10", 0, 1'b1, 32'hFFFFFFFD, 32'd10, earlyCyc,
                  {32'hFFFFFFFD, 32'd0}, 1'b0);

        $display("[TB] two bits per cycle");
        runDivide("bpc2_u100_7", 1, 1'b0, 32'd100, 32'd7, 17, {32'd2, 32'd14}, 1'b0);
        runDivide("bpc2_sneg7_2", 1, 1'b1, 32'hFFFFFFF9, 32'd2, 17,
                  {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
